// File: rtl/spr_shp_window_gen.sv
// Sharpening window generator: turns a stream of 4-pixel groups into 6-pixel
// windows (left neighbour, the group itself, right neighbour) per RGB channel.
module spr_shp_window_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [47:0] in_r,
  input  logic [47:0] in_g,
  input  logic [47:0] in_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [71:0] win_r,
  output logic [71:0] win_g,
  output logic [71:0] win_b,
  output logic [10:0] o_grp_idx
);

  localparam int unsigned PIX_W = 12;
  localparam int unsigned GRP_W = 4 * PIX_W;
  localparam int unsigned IDX_W = 11;
  localparam int unsigned LAST_LO = GRP_W - PIX_W;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               armed_q;
  logic               hs_d1;
  logic               vs_d1;
  logic [GRP_W-1:0]   hold_r;
  logic [GRP_W-1:0]   hold_g;
  logic [GRP_W-1:0]   hold_b;
  logic [PIX_W-1:0]   prev_r;
  logic [PIX_W-1:0]   prev_g;
  logic [PIX_W-1:0]   prev_b;
  logic [IDX_W-1:0]   cnt_q;

  logic               vs_rise_c;
  logic               capture_c;
  logic               issue_c;
  logic [PIX_W-1:0]   nxt_r_c;
  logic [PIX_W-1:0]   nxt_g_c;
  logic [PIX_W-1:0]   nxt_b_c;

  // Decode: a frame start overrides everything and silently drops the held group.
  always_comb begin
    vs_rise_c = i_vs & ~vs_d1;
    capture_c = 1'b0;
    issue_c   = 1'b0;
    if (!vs_rise_c) begin
      case (state_q)
        EMPTY: capture_c = i_de & armed_q;
        HOLD: begin
          issue_c   = 1'b1;
          capture_c = i_de;
        end
        default: ;
      endcase
    end
    state_d = capture_c ? HOLD : EMPTY;
    // Right neighbour comes from the incoming group, or replicates the edge on flush.
    nxt_r_c = i_de ? in_r[PIX_W-1:0] : hold_r[GRP_W-1:LAST_LO];
    nxt_g_c = i_de ? in_g[PIX_W-1:0] : hold_g[GRP_W-1:LAST_LO];
    nxt_b_c = i_de ? in_b[PIX_W-1:0] : hold_b[GRP_W-1:LAST_LO];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      armed_q   <= 1'b0;
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
      o_hs      <= 1'b0;
      o_vs      <= 1'b0;
      o_de      <= 1'b0;
      win_r     <= '0;
      win_g     <= '0;
      win_b     <= '0;
      o_grp_idx <= '0;
      cnt_q     <= '0;
      hold_r    <= '0;
      hold_g    <= '0;
      hold_b    <= '0;
      prev_r    <= '0;
      prev_g    <= '0;
      prev_b    <= '0;
    end else begin
      hs_d1   <= i_hs;
      vs_d1   <= i_vs;
      o_hs    <= hs_d1;
      o_vs    <= vs_d1;
      o_de    <= issue_c;
      state_q <= state_d;

      // Only a line whose start was seen (i_de low first) may open a new window run.
      if (vs_rise_c)
        armed_q <= 1'b0;
      else if (!i_de)
        armed_q <= 1'b1;

      if (issue_c) begin
        win_r     <= {nxt_r_c, hold_r, prev_r};
        win_g     <= {nxt_g_c, hold_g, prev_g};
        win_b     <= {nxt_b_c, hold_b, prev_b};
        o_grp_idx <= cnt_q;
      end

      if (capture_c && (state_q == EMPTY))
        cnt_q <= '0;
      else if (issue_c)
        cnt_q <= cnt_q + IDX_W'(1);

      if (capture_c) begin
        hold_r <= in_r;
        hold_g <= in_g;
        hold_b <= in_b;
        prev_r <= (state_q == HOLD) ? hold_r[GRP_W-1:LAST_LO] : in_r[PIX_W-1:0];
        prev_g <= (state_q == HOLD) ? hold_g[GRP_W-1:LAST_LO] : in_g[PIX_W-1:0];
        prev_b <= (state_q == HOLD) ? hold_b[GRP_W-1:LAST_LO] : in_b[PIX_W-1:0];
      end
    end
  end

endmodule

// File: doc/spr_shp_window_gen.md
SPR_SHP_WINDOW_GEN -- requirements
Module: spr_shp_window_gen

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports i_hs, i_vs, input, 1 each, input sync, active high.
REQ-004 SHALL have port i_de, input, 1, group valid; contiguous per line; a falling edge ends the line.
REQ-005 SHALL have ports in_r, in_g, in_b, input, 48 each, 4 pixels x 12 bit; pixel p at [12p+11:12p], p=0 leftmost.
REQ-006 SHALL have ports o_hs, o_vs, o_de, output, 1 each, syncs aligned to the windows.
REQ-007 SHALL have ports win_r, win_g, win_b, output, 72 each, 6 pixels x 12 bit: [11:0]=prev, [23:12]..[59:48]=cur0..cur3, [71:60]=next.
REQ-008 SHALL have port o_grp_idx, output, 11, index of the current group within the line.

Function
REQ-009 SHALL, per channel, pack each accepted group G(k) into one window: cur0..cur3 = G(k) pixels 0..3.
REQ-010 SHALL set prev = G(k-1) pixel 3, or G(k) pixel 0 (edge replication) when k=0.
REQ-011 SHALL set next = G(k+1) pixel 0, or G(k) pixel 3 (edge replication) when G(k) is the last group of the line.
REQ-012 SHALL use a two-state FSM: EMPTY (no group held) and HOLD (one group held awaiting its right neighbour).
REQ-013 SHALL, in EMPTY with i_de=1: capture the group, record prev replication, and go to HOLD; no window issued.
REQ-014 SHALL, in HOLD with i_de=1: issue the window for the held group, capture the new group, and stay in HOLD.
REQ-015 SHALL, in HOLD with i_de=0: issue the flush window (right-edge replication) and go to EMPTY.
REQ-016 SHALL register every window, so window G(k) appears on outputs exactly 2 cycles after G(k) was presented.
REQ-017 SHALL delay o_hs, o_vs and o_de by exactly 2 cycles from i_hs, i_vs and i_de.
REQ-018 SHALL assert o_de only in cycles carrying a valid window; win_* and o_grp_idx hold their last value while o_de=0.
REQ-019 SHALL reset o_grp_idx to 0 on the first window of each line, increment it per window, and wrap 2047 to 0.
REQ-020 SHALL handle a single-group line as: prev=G[0], next=G[3], o_grp_idx=0.
REQ-021 SHALL, on an i_vs rising edge, return the FSM to EMPTY and drop any held group without issuing a window; the sync delay line keeps running.
REQ-022 SHALL pass pixel values unmodified (no arithmetic); R, G and B share one FSM and counter.

Reset
REQ-023 SHALL, while rst_n=0, force FSM=EMPTY and clear all of the following to 0: o_hs, o_vs, o_de, win_r, win_g, win_b, o_grp_idx, the held group and the sync delay line.
REQ-024 SHALL, on rst_n asserted mid-line, discard the held group, output no flush window, and restart cleanly at the next i_de rising edge.

Verification
REQ-025 SHALL pass the 3-group line scenario: in_r groups {1,2,3,4},{5,6,7,8},{9,10,11,12} on consecutive i_de cycles -> win_r pixels (prev..next) = {1,1,2,3,4,5}, {4,5,6,7,8,9}, {8,9,10,11,12,12}, with o_de high for 3 cycles starting 2 cycles after the first group and o_grp_idx = 0,1,2.
REQ-026 SHALL pass the single-group scenario: group {0xFFF,0,0xFFF,0} -> one window {0xFFF,0xFFF,0,0xFFF,0,0}, o_grp_idx=0.
REQ-027 SHALL pass the back-to-back lines scenario: line A ends, one idle cycle, line B starts -> line A flush window is correct, line B's first window uses left replication with no pixel leakage from line A, and o_grp_idx restarts at 0.
REQ-028 SHALL pass the mid-line reset scenario: rst_n low for 1 cycle during group 5 of 10 -> all outputs 0 during reset, no flush window, and the next line is correct from idx 0.
REQ-029 SHALL pass the i_vs-mid-line scenario: i_vs rises while in HOLD -> the held group is dropped, no o_de pulse for it, and o_vs follows i_vs with 2 cycles delay.
REQ-030 SHALL pass the wrap scenario: a 2049-group line -> o_grp_idx runs 2046, 2047, 0 on the last three windows.
